// File: rtl/boid_frame_scheduler.sv
// Framebuffer sequencer: on each refresh trigger, pulse a buffer swap, then walk
// the active boids and write each on-screen pixel address into the display RAM.
module boid_frame_scheduler #(
    parameter int MAX_BOIDS      = 64,
    parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
    parameter int PIXEL_COUNT    = 307200,
    parameter int ADDR_W         = 19,
    parameter int DIV_LOG2       = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      screen_end,
    input  logic                      cpu_refresh,
    input  logic [1:0]                mode,
    input  logic [BITS_FOR_BOIDS:0]   num_boids,
    input  logic [ADDR_W-1:0]         boid_addr,
    output logic [BITS_FOR_BOIDS-1:0] boid_sel,
    output logic                      disp_we,
    output logic [ADDR_W-1:0]         disp_waddr,
    output logic                      buf_swap,
    output logic                      busy,
    output logic                      frame_done,
    output logic [7:0]                overrun_cnt
);

    localparam logic [BITS_FOR_BOIDS:0] MAX_N     = (BITS_FOR_BOIDS+1)'(MAX_BOIDS);
    localparam logic [ADDR_W-1:0]       PIX_LIMIT = ADDR_W'(PIXEL_COUNT);

    typedef enum logic [1:0] {IDLE, SWAP, SCAN, DRAIN} state_t;

    state_t                  state, state_next;
    logic                    pending, pending_next;
    logic                    ovr_inc;
    logic                    cpu_prev, se_prev;
    logic                    cpu_rise, se_rise, trig;
    logic [DIV_LOG2-1:0]     div_cnt;
    logic [BITS_FOR_BOIDS:0] n_lat, n_clamped;
    logic                    scan_last;

    // NOTE: edge history is deliberately outside reset so a level already high
    // when reset releases is treated as old news, not as a fresh edge.
    always_ff @(posedge clock) begin
        cpu_prev <= cpu_refresh;
        se_prev  <= screen_end;
    end

    always_comb begin
        cpu_rise  = cpu_refresh & ~cpu_prev;
        se_rise   = screen_end & ~se_prev;
        n_clamped = (num_boids > MAX_N) ? MAX_N : num_boids;
        scan_last = ({1'b0, boid_sel} == n_lat - 1'b1);
        case (mode)
            2'b01:   trig = cpu_rise;
            2'b10:   trig = se_rise;
            2'b11:   trig = se_rise & (&div_cnt);
            default: trig = 1'b0;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        ovr_inc      = 1'b0;
        case (state)
            IDLE: begin
                // A queued trigger left over from DRAIN starts the next frame here.
                if (trig || pending) begin
                    state_next   = SWAP;
                    pending_next = pending & trig;
                end
            end
            SWAP, SCAN: begin
                if (state == SWAP)
                    state_next = (n_clamped == '0) ? DRAIN : SCAN;
                else if (scan_last)
                    state_next = DRAIN;
                if (trig) begin
                    if (pending) ovr_inc = 1'b1;
                    else         pending_next = 1'b1;
                end
            end
            DRAIN: begin
                state_next   = pending ? SWAP : IDLE;
                pending_next = trig;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt     <= '0;
            overrun_cnt <= '0;
            n_lat       <= '0;
            boid_sel    <= '0;
            disp_we     <= 1'b0;
            disp_waddr  <= '0;
        end else begin
            if (mode == 2'b11 && se_rise)
                div_cnt <= div_cnt + 1'b1;
            if (ovr_inc && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            if (state == SWAP) begin
                n_lat    <= n_clamped;
                boid_sel <= '0;
            end else if (state == SCAN && !scan_last) begin
                boid_sel <= boid_sel + 1'b1;
            end
            // Off-screen addresses still occupy their scan slot; only the write is dropped.
            disp_we <= (state == SCAN) && (boid_addr < PIX_LIMIT);
            if (state == SCAN)
                disp_waddr <= boid_addr;
        end
    end

    assign buf_swap   = (state == SWAP);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DRAIN);

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Bench for boid_frame_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a frame-schedule reference model.
module tb_boid_frame_scheduler;

    localparam int MAXB = 64;
    localparam int PIX  = 307200;
    localparam int DIV  = 16;

    logic        clock = 1'b0;
    logic        reset, screen_end, cpu_refresh;
    logic [1:0]  mode;
    logic [6:0]  num_boids;
    logic [18:0] boid_addr;
    logic [5:0]  boid_sel;
    logic        disp_we;
    logic [18:0] disp_waddr;
    logic        buf_swap, busy, frame_done;
    logic [7:0]  overrun_cnt;

    logic [18:0] tab [MAXB];
    assign boid_addr = tab[boid_sel];

    always #5 clock = ~clock;

    boid_frame_scheduler dut (
        .clock(clock), .reset(reset), .screen_end(screen_end), .cpu_refresh(cpu_refresh),
        .mode(mode), .num_boids(num_boids), .boid_addr(boid_addr), .boid_sel(boid_sel),
        .disp_we(disp_we), .disp_waddr(disp_waddr), .buf_swap(buf_swap), .busy(busy),
        .frame_done(frame_done), .overrun_cnt(overrun_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: a frame is a window starting at its swap cycle m_s,
    // lasting m_n+2 cycles; triggers outside a window start one, inside it queue.
    bit          m_active, m_sched, m_pend, m_prev_cpu, m_prev_se;
    int          m_s, m_n, m_ovr, m_edges;
    logic [5:0]  exp_sel;
    logic [18:0] exp_waddr;

    int n_swap, n_wr, n_done, first_swap, last_swap, first_we, last_we;
    int first_done, last_done, last_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        n_swap = 0; n_wr = 0; n_done = 0;
        first_swap = -1; last_swap = -1; first_we = -1; last_we = -1;
        first_done = -1; last_done = -1; last_busy = -1;
    endtask

    task automatic step();
        int rel;
        bit e_swap, e_done, e_busy, e_we, trig, cpu_rise, se_rise;
        rel = 0; e_swap = 0; e_done = 0; e_busy = 0; e_we = 0;
        if (m_sched) begin
            m_sched  = 0;
            m_active = 1;
            m_s      = cyc;
            m_n      = (num_boids > MAXB) ? MAXB : int'(num_boids);
        end
        if (m_active) begin
            rel    = cyc - m_s;
            e_busy = 1;
            e_swap = (rel == 0);
            e_done = (rel == m_n + 1);
            if (rel == 1)                    exp_sel = 6'd0;
            else if (rel >= 2 && rel <= m_n) exp_sel = 6'(rel - 1);
            if (rel >= 2 && rel <= m_n + 1) begin
                exp_waddr = tab[rel-2];
                e_we      = (tab[rel-2] < PIX);
            end
        end
        check("busy", busy, e_busy);
        check("buf_swap", buf_swap, e_swap);
        check("frame_done", frame_done, e_done);
        check("disp_we", disp_we, e_we);
        check("disp_waddr", disp_waddr, exp_waddr);
        check("boid_sel", boid_sel, exp_sel);
        check("overrun_cnt", overrun_cnt, m_ovr);

        if (buf_swap) begin
            if (first_swap < 0) first_swap = cyc;
            last_swap = cyc; n_swap++;
        end
        if (disp_we) begin
            if (first_we < 0) first_we = cyc;
            last_we = cyc; n_wr++;
        end
        if (frame_done) begin
            if (first_done < 0) first_done = cyc;
            last_done = cyc; n_done++;
        end
        if (busy) last_busy = cyc;

        cpu_rise = cpu_refresh && !m_prev_cpu;
        se_rise  = screen_end && !m_prev_se;
        case (mode)
            2'd1:    trig = cpu_rise;
            2'd2:    trig = se_rise;
            2'd3:    trig = se_rise && (m_edges % DIV == DIV - 1);
            default: trig = 0;
        endcase
        if (mode == 2'd3 && se_rise) m_edges++;
        m_prev_cpu = cpu_refresh;
        m_prev_se  = screen_end;

        if (reset) begin
            m_active = 0; m_sched = 0; m_pend = 0; m_ovr = 0; m_edges = 0;
            exp_sel = '0; exp_waddr = '0;
        end else if (!m_active) begin
            if (trig || m_pend) begin
                m_sched = 1;
                m_pend  = m_pend && trig;
            end
        end else if (rel == m_n + 1) begin
            m_active = 0;
            if (m_pend) m_sched = 1;
            m_pend = trig;
        end else if (trig) begin
            if (m_pend) begin
                if (m_ovr < 255) m_ovr++;
            end else begin
                m_pend = 1;
            end
        end

        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (m_active || m_sched || m_pend); i++) step();
        step();
        check("idle_wait", busy, 0);
    endtask

    task automatic rand_tab();
        for (int i = 0; i < MAXB; i++) begin
            case ($urandom_range(0, 4))
                0:       tab[i] = 19'(PIX);
                1:       tab[i] = 19'(PIX - 1);
                2:       tab[i] = 19'($urandom_range(PIX, 524287));
                default: tab[i] = 19'($urandom_range(0, PIX - 1));
            endcase
        end
    endtask

    // Fires a CPU trigger in the current cycle; returns that cycle number.
    task automatic cpu_trigger(output int t);
        t = cyc;
        cpu_refresh = 1'b1; step();
        cpu_refresh = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int t0, e16, e32;
        reset = 1'b1; screen_end = 1'b0; cpu_refresh = 1'b0; mode = 2'd1; num_boids = 7'd4;
        for (int i = 0; i < MAXB; i++) tab[i] = 19'(100 + i);
        m_active = 0; m_sched = 0; m_pend = 0; m_prev_cpu = 0; m_prev_se = 0;
        m_s = 0; m_n = 0; m_ovr = 0; m_edges = 0; exp_sel = '0; exp_waddr = '0;
        clear_obs();
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_swap", buf_swap, 0);
        check("rst_we", disp_we, 0);
        check("rst_sel", boid_sel, 0);
        check("rst_ovr", overrun_cnt, 0);
        step();
        reset = 1'b0;
        repeat (3) step();

        // Basic scan, addresses 100..103
        clear_obs();
        cpu_trigger(t0);
        wait_idle();
        check("basic_swap_at", first_swap, t0 + 1);
        check("basic_writes", n_wr, 4);
        check("basic_first_we", first_we, t0 + 3);
        check("basic_last_we", last_we, t0 + 6);
        check("basic_done_at", last_done, t0 + 6);
        check("basic_last_busy", last_busy, t0 + 6);
        check("basic_sel_hold", boid_sel, 3);

        // Off-screen boid 2 is skipped without stretching the scan
        tab[2] = 19'(PIX);
        clear_obs();
        cpu_trigger(t0);
        wait_idle();
        check("skip_writes", n_wr, 3);
        check("skip_done_at", last_done, t0 + 6);

        // Zero boids
        num_boids = 7'd0;
        clear_obs();
        cpu_trigger(t0);
        wait_idle();
        check("zero_swap_at", first_swap, t0 + 1);
        check("zero_done_at", last_done, t0 + 2);
        check("zero_writes", n_wr, 0);

        // Count above MAX_BOIDS is clamped
        tab[2] = 19'd102;
        num_boids = 7'd100;
        clear_obs();
        cpu_trigger(t0);
        wait_idle();
        check("clamp_writes", n_wr, 64);
        check("clamp_done_at", last_done, t0 + 66);

        // Overrun: start + two more triggers inside one 64-boid scan
        num_boids = 7'd64;
        clear_obs();
        cpu_trigger(t0);
        repeat (9) step();
        cpu_refresh = 1'b1; step(); cpu_refresh = 1'b0;
        repeat (9) step();
        cpu_refresh = 1'b1; step(); cpu_refresh = 1'b0;
        wait_idle();
        check("ovr_count", overrun_cnt, 1);
        check("ovr_frames", n_swap, 2);
        check("ovr_first_done", first_done, t0 + 66);
        check("ovr_backtoback", last_swap, first_done + 1);

        // Divided screen_end: 40 edges give swaps after edges 16 and 32 only
        mode = 2'd3; num_boids = 7'd2;
        clear_obs();
        e16 = -1; e32 = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 16) e16 = cyc;
            if (k == 32) e32 = cyc;
            screen_end = 1'b1; step();
            screen_end = 1'b0; repeat (3) step();
        end
        wait_idle();
        check("div_frames", n_swap, 2);
        check("div_swap16", first_swap, e16 + 1);
        check("div_swap32", last_swap, e32 + 1);

        // Reset at scan index 5, CPU request held high through release
        mode = 2'd1; num_boids = 7'd10;
        cpu_trigger(t0);
        while (cyc < t0 + 7) step();
        check("mid_sel5", boid_sel, 5);
        reset = 1'b1; cpu_refresh = 1'b1;
        step();
        reset = 1'b0;
        check("mid_busy", busy, 0);
        check("mid_we", disp_we, 0);
        check("mid_sel", boid_sel, 0);
        check("mid_waddr", disp_waddr, 0);
        check("mid_ovr", overrun_cnt, 0);
        clear_obs();
        repeat (10) step();
        check("mid_no_trig", n_swap, 0);
        cpu_refresh = 1'b0;
        repeat (2) step();

        // Mode 00: random activity must never start a frame
        mode = 2'd0;
        clear_obs();
        for (int i = 0; i < 300; i++) begin
            cpu_refresh = 1'($urandom_range(0, 1));
            screen_end  = 1'($urandom_range(0, 1));
            step();
        end
        check("off_frames", n_swap, 0);
        cpu_refresh = 1'b0; screen_end = 1'b0;
        repeat (2) step();

        // Mode 10: random screen_end traffic with random tables and counts
        rand_tab();
        mode = 2'd2;
        for (int i = 0; i < 1500; i++) begin
            screen_end = ($urandom_range(0, 5) == 0);
            num_boids  = 7'($urandom_range(0, 80));
            step();
        end
        screen_end = 1'b0;
        wait_idle();

        // Mode 01 flood: heavy CPU traffic drives overrun_cnt to saturation
        rand_tab();
        mode = 2'd1;
        for (int i = 0; i < 2500; i++) begin
            cpu_refresh = 1'($urandom_range(0, 1));
            num_boids   = 7'($urandom_range(0, 90));
            step();
        end
        cpu_refresh = 1'b0;
        wait_idle();
        check("ovr_saturated", overrun_cnt, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
